// File: rtl/timer_scheduler.sv
// Round-robin scheduler sharing one one-shot compare timer between N_CH requesters.
// Grants a request, drives clear/arm/enable of the timer and reports done/aborted per channel.
module timer_scheduler #(
    parameter int N_CH  = 4,
    parameter int WIDTH = 16,
    localparam int IDW  = $clog2(N_CH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_CH-1:0]         req_valid,
    input  logic [N_CH*WIDTH-1:0]   req_delay,
    output logic [N_CH-1:0]         req_ack,
    input  logic [N_CH-1:0]         cancel,
    output logic [N_CH-1:0]         done,
    output logic [N_CH-1:0]         aborted,
    output logic                    busy,
    output logic [IDW-1:0]          active_id,
    output logic                    timer_enable,
    output logic                    timer_clear,
    output logic [WIDTH-1:0]        timer_compare,
    input  logic                    timer_irq
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_RUN,
        S_DONE,
        S_FLUSH
    } state_t;

    state_t              r_state;
    logic [IDW-1:0]      r_rr_ptr;
    logic [N_CH-1:0]     r_ack;
    logic [N_CH-1:0]     r_done;
    logic [N_CH-1:0]     r_aborted;
    logic                r_busy;
    logic [IDW-1:0]      r_active_id;
    logic                r_enable;
    logic                r_clear;
    logic [WIDTH-1:0]    r_compare;

    state_t              w_state_nxt;
    logic [IDW-1:0]      w_rr_nxt;
    logic [N_CH-1:0]     w_ack_nxt;
    logic [N_CH-1:0]     w_done_nxt;
    logic [N_CH-1:0]     w_aborted_nxt;
    logic [IDW-1:0]      w_id_nxt;
    logic                w_enable_nxt;
    logic                w_clear_nxt;
    logic [WIDTH-1:0]    w_compare_nxt;
    logic                w_found;
    logic [IDW-1:0]      w_win;
    logic [IDW-1:0]      w_cand;
    logic                w_cancel_act;

    // Round-robin search: first pending channel at or above rr_ptr, wrapping modulo N_CH.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_cand  = '0;
        for (int k = 0; k < N_CH; k++) begin
            w_cand = IDW'((int'(r_rr_ptr) + k) % N_CH);
            if (!w_found && req_valid[w_cand]) begin
                w_found = 1'b1;
                w_win   = w_cand;
            end
        end
    end

    assign w_cancel_act = cancel[r_active_id];

    always_comb begin
        w_state_nxt   = r_state;
        w_rr_nxt      = r_rr_ptr;
        w_ack_nxt     = '0;
        w_done_nxt    = '0;
        w_aborted_nxt = '0;
        w_id_nxt      = r_active_id;
        w_enable_nxt  = 1'b0;
        w_clear_nxt   = 1'b0;
        w_compare_nxt = r_compare;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_nxt       = S_ARM;
                    w_ack_nxt[w_win]  = 1'b1;
                    w_id_nxt          = w_win;
                    w_compare_nxt     = req_delay[int'(w_win)*WIDTH +: WIDTH];
                    w_clear_nxt       = 1'b1;
                    if (int'(w_win) == N_CH - 1) begin
                        w_rr_nxt = '0;
                    end else begin
                        w_rr_nxt = w_win + IDW'(1);
                    end
                end
            end
            S_ARM: begin
                if (w_cancel_act) begin
                    w_state_nxt                = S_FLUSH;
                    w_aborted_nxt[r_active_id] = 1'b1;
                    w_clear_nxt                = 1'b1;
                end else begin
                    w_state_nxt  = S_RUN;
                    w_enable_nxt = 1'b1;
                end
            end
            S_RUN: begin
                // Expiry takes priority over a same-cycle cancel.
                if (timer_irq) begin
                    w_state_nxt             = S_DONE;
                    w_done_nxt[r_active_id] = 1'b1;
                    w_clear_nxt             = 1'b1;
                end else if (w_cancel_act) begin
                    w_state_nxt                = S_FLUSH;
                    w_aborted_nxt[r_active_id] = 1'b1;
                    w_clear_nxt                = 1'b1;
                end else begin
                    w_enable_nxt = 1'b1;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            S_FLUSH: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Outputs are registered from the next-state decode so they line up with the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_rr_ptr    <= '0;
            r_ack       <= '0;
            r_done      <= '0;
            r_aborted   <= '0;
            r_busy      <= 1'b0;
            r_active_id <= '0;
            r_enable    <= 1'b0;
            r_clear     <= 1'b0;
            r_compare   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_rr_ptr    <= w_rr_nxt;
            r_ack       <= w_ack_nxt;
            r_done      <= w_done_nxt;
            r_aborted   <= w_aborted_nxt;
            r_busy      <= (w_state_nxt != S_IDLE);
            r_active_id <= w_id_nxt;
            r_enable    <= w_enable_nxt;
            r_clear     <= w_clear_nxt;
            r_compare   <= w_compare_nxt;
        end
    end

    assign req_ack       = r_ack;
    assign done          = r_done;
    assign aborted       = r_aborted;
    assign busy          = r_busy;
    assign active_id     = r_active_id;
    assign timer_enable  = r_enable;
    assign timer_clear   = r_clear;
    assign timer_compare = r_compare;

endmodule

// File: tb/tb_timer_scheduler.sv
// Directed bench for timer_scheduler with a behavioural one-shot compare timer attached.
module tb_timer_scheduler;

    localparam int N = 4;
    localparam int W = 16;

    logic           clk;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_delay;
    logic [N-1:0]   req_ack;
    logic [N-1:0]   cancel;
    logic [N-1:0]   done;
    logic [N-1:0]   aborted;
    logic           busy;
    logic [1:0]     active_id;
    logic           timer_enable;
    logic           timer_clear;
    logic [W-1:0]   timer_compare;
    logic           timer_irq;

    int n_vec;
    int n_err;

    timer_scheduler #(.N_CH(N), .WIDTH(W)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_delay     (req_delay),
        .req_ack       (req_ack),
        .cancel        (cancel),
        .done          (done),
        .aborted       (aborted),
        .busy          (busy),
        .active_id     (active_id),
        .timer_enable  (timer_enable),
        .timer_clear   (timer_clear),
        .timer_compare (timer_compare),
        .timer_irq     (timer_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One-shot compare timer: counts while enabled, irq registered and sticky until clear.
    logic [W-1:0] tm_cnt;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tm_cnt    <= '0;
            timer_irq <= 1'b0;
        end else if (timer_clear) begin
            tm_cnt    <= '0;
            timer_irq <= 1'b0;
        end else if (timer_enable) begin
            if (tm_cnt == timer_compare) timer_irq <= 1'b1;
            tm_cnt <= tm_cnt + 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_evt(input int limit, output int k, output logic [N-1:0] d,
                            output logic [N-1:0] a);
        k = 0;
        d = '0;
        a = '0;
        while (k < limit) begin
            tick();
            k++;
            if ((done | aborted) != '0) begin
                d = done;
                a = aborted;
                break;
            end
        end
    endtask

    task automatic set_delay(input int ch, input logic [W-1:0] dly);
        req_delay[ch*W +: W] = dly;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ack"},  32'(req_ack), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_abrt"}, 32'(aborted), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_id"},   32'(active_id), 0);
        chk({tag, "_en"},   32'(timer_enable), 0);
        chk({tag, "_clr"},  32'(timer_clear), 0);
        chk({tag, "_cmp"},  32'(timer_compare), 0);
    endtask

    int           k;
    logic [N-1:0] d;
    logic [N-1:0] a;
    logic [N-1:0] seen;
    logic [N-1:0] exp_oh;

    initial begin
        n_vec     = 0;
        n_err     = 0;
        rst       = 1'b1;
        req_valid = '0;
        req_delay = '0;
        cancel    = '0;
        tick();
        tick();
        chk_all_zero("rst");
        rst = 1'b0;

        // Test 1: single request ch0, delay 5 -> ack at T+1, done at T+9
        set_delay(0, 16'd5);
        req_valid = 4'b0001;
        tick();
        chk("t1_ack", 32'(req_ack), 32'h1);
        chk("t1_clr_arm", 32'(timer_clear), 1);
        chk("t1_busy", 32'(busy), 1);
        chk("t1_cmp", 32'(timer_compare), 5);
        chk("t1_id", 32'(active_id), 0);
        req_valid = '0;
        tick();
        chk("t1_en_run", 32'(timer_enable), 1);
        chk("t1_clr_run", 32'(timer_clear), 0);
        wait_evt(20, k, d, a);
        chk("t1_lat", 32'(k + 1), 8);
        chk("t1_done", 32'(d), 32'h1);
        chk("t1_abrt", 32'(a), 0);
        chk("t1_clr_done", 32'(timer_clear), 1);
        tick();
        chk("t1_idle", 32'(busy), 0);
        chk("t1_done_once", 32'(done), 0);

        // Test 2: all channels together from rr_ptr=0, delay 3 -> 0,1,2,3
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int c = 0; c < N; c++) set_delay(c, 16'd3);
        req_valid = 4'b1111;
        tick();
        for (int c = 0; c < N; c++) begin
            exp_oh = N'(1) << c;
            chk($sformatf("t2_ack%0d", c), 32'(req_ack), 32'(exp_oh));
            chk($sformatf("t2_id%0d", c), 32'(active_id), c);
            req_valid = req_valid & ~exp_oh;
            wait_evt(20, k, d, a);
            chk($sformatf("t2_lat%0d", c), 32'(k), 6);
            chk($sformatf("t2_done%0d", c), 32'(d), 32'(exp_oh));
            tick();
            chk($sformatf("t2_gap%0d", c), 32'(busy), 0);
            if (c < N - 1) tick();
        end

        // Test 3: cancel active ch2 in RUN -> FLUSH with aborted[2]
        set_delay(2, 16'd100);
        req_valid = 4'b0100;
        tick();
        chk("t3_ack", 32'(req_ack), 32'h4);
        req_valid = '0;
        tick();
        tick();
        cancel = 4'b0100;
        tick();
        cancel = '0;
        chk("t3_abrt", 32'(aborted), 32'h4);
        chk("t3_done", 32'(done), 0);
        chk("t3_clr", 32'(timer_clear), 1);
        chk("t3_en", 32'(timer_enable), 0);
        tick();
        chk("t3_busy", 32'(busy), 0);
        seen = '0;
        repeat (120) begin
            tick();
            seen = seen | done | aborted;
        end
        chk("t3_quiet", 32'(seen), 0);

        // Test 4a: cancel on a non-active channel is ignored
        set_delay(2, 16'd4);
        req_valid = 4'b0100;
        tick();
        chk("t4a_ack", 32'(req_ack), 32'h4);
        req_valid = '0;
        tick();
        tick();
        cancel = 4'b0010;
        tick();
        cancel = '0;
        wait_evt(20, k, d, a);
        chk("t4a_lat", 32'(k), 4);
        chk("t4a_done", 32'(d), 32'h4);
        chk("t4a_abrt", 32'(a), 0);
        tick();

        // Test 4b: cancel on the irq cycle -> done wins
        set_delay(2, 16'd2);
        req_valid = 4'b0100;
        tick();
        chk("t4b_ack", 32'(req_ack), 32'h4);
        req_valid = '0;
        repeat (4) tick();
        cancel = 4'b0100;
        tick();
        cancel = '0;
        chk("t4b_done", 32'(done), 32'h4);
        chk("t4b_abrt", 32'(aborted), 0);
        tick();

        // Test 5: extreme delays
        set_delay(0, 16'd0);
        req_valid = 4'b0001;
        tick();
        chk("t5_ack0", 32'(req_ack), 32'h1);
        req_valid = '0;
        wait_evt(20, k, d, a);
        chk("t5_lat0", 32'(k), 3);
        chk("t5_done0", 32'(d), 32'h1);
        tick();
        set_delay(0, 16'hFFFF);
        req_valid = 4'b0001;
        tick();
        chk("t5_ackmax", 32'(req_ack), 32'h1);
        chk("t5_cmpmax", 32'(timer_compare), 32'hFFFF);
        req_valid = '0;
        wait_evt(70000, k, d, a);
        chk("t5_latmax", 32'(k), 65538);
        chk("t5_donemax", 32'(d), 32'h1);
        tick();

        // Test 6: async reset during RUN
        set_delay(1, 16'd50);
        req_valid = 4'b0010;
        tick();
        chk("t6_ack", 32'(req_ack), 32'h2);
        req_valid = '0;
        tick();
        tick();
        chk("t6_run", 32'(timer_enable), 1);
        #2;
        rst = 1'b1;
        #1;
        chk_all_zero("t6_async");
        tick();
        rst = 1'b0;
        seen = '0;
        repeat (70) begin
            tick();
            seen = seen | done | aborted;
        end
        chk("t6_quiet", 32'(seen), 0);
        chk("t6_idle", 32'(busy), 0);
        req_valid = 4'b1111;
        tick();
        chk("t6_rrptr", 32'(req_ack), 32'h1);
        req_valid = '0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
